// File: rtl/sha256_stream_node_if.sv
// Word-stream bus for sha256_stream_node: message words in, digest words out.
// The node takes the slave view; whoever feeds and drains it takes the master view.
interface sha256_stream_node_if #(
  parameter int in_width_p  = 32,
  parameter int out_width_p = 32
);
  logic                   v_i;
  logic [in_width_p-1:0]  data_i;
  logic                   last_i;
  logic                   ready_o;
  logic                   v_o;
  logic [out_width_p-1:0] data_o;
  logic                   last_o;
  logic                   yumi_i;

  modport master (output v_i, data_i, last_i, yumi_i,
                  input  ready_o, v_o, data_o, last_o);
  modport slave  (input  v_i, data_i, last_i, yumi_i,
                  output ready_o, v_o, data_o, last_o);
endinterface

// File: rtl/sha256_stream_node.sv
// Streaming SHA-256 node: gathers 512-bit blocks, chains them through an iterative
// compression core, then emits the 256-bit digest as out_width_p-bit words.
module sha256_compress (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         v_i,
  output logic         ready_o,
  input  logic [511:0] block_i,
  input  logic [255:0] hash_i,
  output logic         v_o,
  output logic [255:0] hash_o
);
  typedef enum logic {C_IDLE, C_RUN} core_state_e;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  core_state_e  r_state;
  logic         r_ready;
  logic         r_v;
  logic [255:0] r_hash;
  logic [255:0] r_hin;
  logic [5:0]   r_t;
  logic [31:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [31:0]  r_w [16];

  logic [31:0]  w_t1, w_t2, w_wnext, w_na, w_ne;

  // r_w is a sliding window: r_w[0] is W[t], r_w[15] is W[t+15]
  always_comb begin
    w_t1    = r_h + (rotr(r_e, 6) ^ rotr(r_e, 11) ^ rotr(r_e, 25))
            + ((r_e & r_f) ^ (~r_e & r_g)) + K[r_t] + r_w[0];
    w_t2    = (rotr(r_a, 2) ^ rotr(r_a, 13) ^ rotr(r_a, 22))
            + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));
    w_wnext = (rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10)) + r_w[9]
            + (rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3)) + r_w[0];
    w_na    = w_t1 + w_t2;
    w_ne    = r_d + w_t1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= C_IDLE;
      r_ready <= 1'b1;
      r_v     <= 1'b0;
      r_hash  <= '0;
      r_hin   <= '0;
      r_t     <= '0;
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
      for (int unsigned k = 0; k < 16; k++) r_w[k] <= '0;
    end else begin
      r_v <= 1'b0;
      unique case (r_state)
        C_IDLE: begin
          if (v_i && r_ready) begin
            r_hin   <= hash_i;
            {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= hash_i;
            for (int unsigned k = 0; k < 16; k++) r_w[k] <= block_i[511 - k*32 -: 32];
            r_t     <= '0;
            r_ready <= 1'b0;
            r_state <= C_RUN;
          end
        end
        C_RUN: begin
          {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= {w_na, r_a, r_b, r_c, w_ne, r_e, r_f, r_g};
          for (int unsigned k = 0; k < 15; k++) r_w[k] <= r_w[k+1];
          r_w[15] <= w_wnext;
          r_t     <= r_t + 6'd1;
          if (r_t == 6'd63) begin
            r_hash  <= {r_hin[255:224] + w_na, r_hin[223:192] + r_a,
                        r_hin[191:160] + r_b,  r_hin[159:128] + r_c,
                        r_hin[127:96]  + w_ne, r_hin[95:64]   + r_e,
                        r_hin[63:32]   + r_f,  r_hin[31:0]    + r_g};
            r_v     <= 1'b1;
            r_ready <= 1'b1;
            r_state <= C_IDLE;
          end
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  assign ready_o = r_ready;
  assign v_o     = r_v;
  assign hash_o  = r_hash;
endmodule

module sha256_stream_node #(
  parameter int in_width_p  = 32,
  parameter int out_width_p = 32,
  parameter int id_p        = 0
) (
  input logic                 clk_i,
  input logic                 reset_i,
  input logic                 en_i,
  sha256_stream_node_if.slave bus
);
  localparam int unsigned N   = 512 / in_width_p;
  localparam int unsigned M   = 256 / out_width_p;
  localparam int unsigned WCW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OCW = (M > 1) ? $clog2(M) : 1;
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  if (512 % in_width_p != 0)  begin : g_bad_in  $error("in_width_p must divide 512");  end
  if (256 % out_width_p != 0) begin : g_bad_out $error("out_width_p must divide 256"); end
  if (id_p < 0)               begin : g_bad_id  $error("id_p must be non-negative");   end

  typedef enum logic [1:0] {S_FILL, S_HASH, S_OUT} state_e;

  state_e         r_state;
  logic           r_live;
  logic           r_last_blk;
  logic           r_core_v;
  logic [WCW-1:0] r_wcnt;
  logic [OCW-1:0] r_ocnt;
  logic [511:0]   r_blk;
  logic [255:0]   r_h;

  logic                   w_accept, w_take, w_core_ready, w_core_v;
  logic [255:0]           w_core_hash;
  logic [out_width_p-1:0] w_word;

  sha256_compress u_core (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (r_core_v),
    .ready_o (w_core_ready),
    .block_i (r_blk),
    .hash_i  (r_h),
    .v_o     (w_core_v),
    .hash_o  (w_core_hash)
  );

  // r_live keeps ready_o low from reset until the first enabled clock edge
  assign bus.ready_o = r_live & en_i & (r_state == S_FILL);
  assign bus.v_o     = en_i & (r_state == S_OUT);
  assign bus.last_o  = bus.v_o & (r_ocnt == OCW'(M - 1));
  assign w_accept    = bus.v_i & bus.ready_o;
  assign w_take      = bus.yumi_i & bus.v_o;

  always_comb begin
    w_word = '0;
    for (int unsigned k = 0; k < M; k++)
      if (r_ocnt == OCW'(k)) w_word = r_h[255 - k*out_width_p -: out_width_p];
    bus.data_o = (r_state == S_OUT) ? w_word : '0;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state    <= S_FILL;
      r_live     <= 1'b0;
      r_last_blk <= 1'b0;
      r_core_v   <= 1'b0;
      r_wcnt     <= '0;
      r_ocnt     <= '0;
      r_blk      <= '0;
      r_h        <= IV;
    end else begin
      r_live <= r_live | en_i;
      unique case (r_state)
        S_FILL: begin
          if (w_accept) begin
            for (int unsigned k = 0; k < N; k++)
              if (r_wcnt == WCW'(k)) r_blk[511 - k*in_width_p -: in_width_p] <= bus.data_i;
            if (r_wcnt == WCW'(N - 1)) begin
              r_last_blk <= bus.last_i;
              r_wcnt     <= '0;
              r_core_v   <= 1'b1;
              r_state    <= S_HASH;
            end else begin
              r_wcnt <= r_wcnt + WCW'(1);
            end
          end
        end
        // Deliberately not gated by en_i so an in-flight block always lands in H
        S_HASH: begin
          if (r_core_v && w_core_ready) r_core_v <= 1'b0;
          if (w_core_v) begin
            r_h     <= w_core_hash;
            r_state <= r_last_blk ? S_OUT : S_FILL;
          end
        end
        S_OUT: begin
          if (w_take) begin
            if (r_ocnt == OCW'(M - 1)) begin
              r_ocnt     <= '0;
              r_h        <= IV;
              r_last_blk <= 1'b0;
              r_state    <= S_FILL;
            end else begin
              r_ocnt <= r_ocnt + OCW'(1);
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_stream_node.sv
// Bench for sha256_stream_node: known-answer digests plus random padded messages
// checked against a plain SHA-256 reference function.
module tb_sha256_stream_node;
  localparam int unsigned CORE_LAT = 64;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  always #5 clk = ~clk;

  sha256_stream_node_if #(.in_width_p(32), .out_width_p(32)) bus ();

  sha256_stream_node #(.in_width_p(32), .out_width_p(32), .id_p(3)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .en_i    (en),
    .bus     (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_digest(input logic [31:0] w[$]);
    logic [31:0] h [8];
    logic [31:0] s [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int blk = 0; blk < w.size() / 16; blk++) begin
      for (int t = 0; t < 16; t++) s[t] = w[blk*16 + t];
      for (int t = 16; t < 64; t++)
        s[t] = (rr(s[t-2], 17) ^ rr(s[t-2], 19) ^ (s[t-2] >> 10)) + s[t-7]
             + (rr(s[t-15], 7) ^ rr(s[t-15], 18) ^ (s[t-15] >> 3)) + s[t-16];
      {a, b, c, d, e, f, g, hh} = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KTAB[t] + s[t];
        t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d;
      h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  task automatic pad_bytes(input byte unsigned b[$], output logic [31:0] w[$]);
    byte unsigned p[$];
    longint unsigned nbits;
    p = b;
    nbits = 64'(b.size()) * 8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(nbits >> (8*i)));
    w = {};
    for (int i = 0; i < p.size(); i += 4) w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
  endtask

  // Leaves the caller on the negedge right after the final accepting edge
  task automatic send(input logic [31:0] w[$], input int nsend, input int pause_at, input bit rnd);
    int guard;
    for (int i = 0; i < nsend; i++) begin
      if (rnd && $urandom_range(3) == 0) begin
        bus.v_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      bus.v_i    = 1'b1;
      bus.data_i = w[i];
      bus.last_i = (i == w.size() - 1) || (rnd && (i % 16 != 15) && $urandom_range(2) == 0);
      if (i == pause_at) begin
        en = 1'b0;
        repeat (5) begin
          #1 check_val("pause_ready", 256'(bus.ready_o), 256'd0);
          @(negedge clk);
        end
        en = 1'b1;
      end
      guard = 0;
      #1;
      while (!bus.ready_o && guard < 200) begin
        @(negedge clk); #1; guard++;
      end
      if (!bus.ready_o) begin
        check_val("ready_timeout", 256'd0, 256'd1);
        bus.v_i = 1'b0;
        return;
      end
      check_val("no_early_vo", 256'(bus.v_o), 256'd0);
      @(negedge clk);
    end
    bus.v_i    = 1'b0;
    bus.last_i = 1'b0;
  endtask

  task automatic recv(input logic [255:0] exp, input int stall_j, input bit chk_lat);
    int lat;
    logic [31:0] ew;
    lat = 0;
    while (!bus.v_o && lat < 300) begin
      @(negedge clk); lat++;
    end
    if (chk_lat) check_val("latency", 256'(lat), 256'(CORE_LAT + 2));
    for (int j = 0; j < 8; j++) begin
      ew = exp[255 - 32*j -: 32];
      check_val("dig_vo", 256'(bus.v_o), 256'd1);
      check_val("dig_word", 256'(bus.data_o), 256'(ew));
      check_val("dig_last", 256'(bus.last_o), 256'(j == 7));
      if (j == stall_j) begin
        repeat (10) begin
          @(negedge clk);
          check_val("stall_word", 256'(bus.data_o), 256'(ew));
          check_val("stall_vo", 256'(bus.v_o), 256'd1);
        end
      end
      bus.yumi_i = bus.v_o;
      @(negedge clk);
      bus.yumi_i = 1'b0;
    end
    check_val("post_vo", 256'(bus.v_o), 256'd0);
    check_val("post_ready", 256'(bus.ready_o), 256'd1);
  endtask

  logic [31:0]  abc_w[$];
  logic [31:0]  two_w[$];
  logic [31:0]  rw[$];
  byte unsigned bq[$];
  string        two_s;
  logic [255:0] rexp;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.v_i = 1'b0; bus.data_i = '0; bus.last_i = 1'b0; bus.yumi_i = 1'b0;
    en = 1'b1; rst_n = 1'b0;
    abc_w = {32'h61626380};
    repeat (14) abc_w.push_back(32'h0);
    abc_w.push_back(32'h00000018);
    two_s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    for (int i = 0; i < two_s.len(); i++) bq.push_back(two_s[i]);
    pad_bytes(bq, two_w);

    repeat (3) @(negedge clk);
    check_val("rst_ready", 256'(bus.ready_o), 256'd0);
    check_val("rst_vo", 256'(bus.v_o), 256'd0);
    check_val("rst_last", 256'(bus.last_o), 256'd0);
    check_val("rst_data", 256'(bus.data_o), 256'd0);
    rst_n = 1'b1;
    #1 check_val("rel_ready_before_edge", 256'(bus.ready_o), 256'd0);
    @(negedge clk);
    check_val("rel_ready_after_edge", 256'(bus.ready_o), 256'd1);

    send(abc_w, 16, -1, 1'b0);  recv(ABC_DIG, -1, 1'b1);
    send(two_w, 32, -1, 1'b0);  recv(TWO_DIG, -1, 1'b1);
    send(abc_w, 16, -1, 1'b0);  recv(ABC_DIG, 3, 1'b1);
    send(abc_w, 16, 7, 1'b0);   recv(ABC_DIG, -1, 1'b1);

    send(abc_w, 9, -1, 1'b0);
    rst_n = 1'b0;
    #1 check_val("midrst_ready", 256'(bus.ready_o), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(abc_w, 16, -1, 1'b0);  recv(ABC_DIG, -1, 1'b1);

    send(abc_w, 16, -1, 1'b0);  recv(ABC_DIG, -1, 1'b1);
    send(abc_w, 16, -1, 1'b0);  recv(ABC_DIG, -1, 1'b1);

    for (int r = 0; r < 6; r++) begin
      bq = {};
      repeat ($urandom_range(0, 130)) bq.push_back(8'($urandom_range(0, 255)));
      pad_bytes(bq, rw);
      rexp = ref_digest(rw);
      send(rw, rw.size(), ($urandom_range(1) == 1) ? int'($urandom_range(0, rw.size() - 1)) : -1, 1'b1);
      recv(rexp, int'($urandom_range(0, 9)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sha256_stream_node.md
SHA256_STREAM_NODE -- requirements
Module: sha256_stream_node

Interface
REQ-001: Parameter in_width_p, default 32, SHALL set the input word width and SHALL divide 512.
REQ-002: Parameter out_width_p, default 32, SHALL set the output word width and SHALL divide 256.
REQ-003: Parameter id_p, default 0, SHALL give the node identifier and SHALL have no functional effect.
REQ-004: clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005: reset_i  input  1  SHALL be the asynchronous, active-low reset.
REQ-006: en_i  input  1  SHALL be the node enable.
REQ-007: v_i  input  1  SHALL mark the input word as valid.
REQ-008: data_i  input  in_width_p  SHALL carry the message word, most significant word of each block first.
REQ-009: last_i  input  1  SHALL mark the final word of a message's final block.
REQ-010: ready_o  output  1  SHALL show that the node can accept a word.
REQ-011: v_o  output  1  SHALL mark the digest word as valid.
REQ-012: data_o  output  out_width_p  SHALL carry the digest word, most significant first.
REQ-013: last_o  output  1  SHALL mark the final digest word.
REQ-014: yumi_i  input  1  SHALL show that the consumer takes data_o this cycle; it SHALL only be asserted while v_o=1.

Function
REQ-015: The node SHALL instantiate compression core sha256_compress (v_i, ready_o, block_i[511:0], hash_i[255:0], v_o, hash_o[255:0]); its v_o SHALL pulse for one cycle per block, after a fixed latency L.
REQ-016: The state machine SHALL have exactly three states: FILL, HASH and OUT; the reset state SHALL be FILL.
REQ-017: An input word SHALL be accepted when v_i & ready_o; ready_o SHALL equal en_i & (state==FILL).
REQ-018: FILL SHALL hold a word counter, 0..N-1 where N=512/in_width_p; word k SHALL be stored at bits [511-k*in_width_p -: in_width_p].
REQ-019: Accepting word N-1 SHALL latch last_i into last_blk, clear the counter and move the state to HASH.
REQ-020: last_i on any word other than word N-1 SHALL be ignored.
REQ-021: HASH SHALL drive core v_i=1 with the assembled block and chain register H until the core's ready_o=1; it SHALL then drop v_i and wait for the core's v_o.
REQ-022: On core v_o, H SHALL be loaded with hash_o.
REQ-023: On core v_o with last_blk=0, the state SHALL return to FILL, keeping H for chaining.
REQ-024: On core v_o with last_blk=1, the state SHALL move to OUT.
REQ-025: H SHALL hold the SHA-256 IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19) at reset and after each message completes.
REQ-026: In OUT, v_o SHALL equal en_i, and data_o SHALL show word j of H, j=0..M-1 where M=256/out_width_p, with word 0 at bits [255:256-out_width_p].
REQ-027: last_o SHALL be v_o & (j==M-1).
REQ-028: j SHALL advance only on yumi_i; data_o SHALL stay stable while v_o=1 and yumi_i=0.
REQ-029: yumi_i with j==M-1 SHALL clear j, reload H with the IV and return the state to FILL, where the next message may start on the next cycle.
REQ-030: While en_i=0, ready_o and v_o SHALL be 0 and the counters SHALL hold; a core operation already in flight SHALL still complete and update H.
REQ-031: Total latency SHALL be L+2 cycles from the accepted final word to the first v_o, given en_i=1.
REQ-032: Inputs SHALL be padded by the sender; the node SHALL NOT add any padding.

Reset
REQ-033: reset_i=0 SHALL set, asynchronously, state=FILL, both counters=0, last_blk=0, H=IV, ready_o=0, v_o=0, last_o=0 and data_o=0.
REQ-034: A reset during any state SHALL discard the partial block and the partial digest; the core SHALL be reset by the same reset_i.
REQ-035: After reset_i releases, ready_o SHALL rise on the first clock edge with en_i=1.

Verification
REQ-036: Stimulus: "abc" padded as 16 32-bit words (61626380, 0 x14, 00000018), last_i on word 15. Required response: 8 words ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with last_o on the 8th.
REQ-037: Stimulus: the 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" as two padded blocks, last_i only on block 2 word 15. Required response: 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, and no output after block 1.
REQ-038: Stimulus: "abc" digest with yumi_i held low for 10 cycles at j=3. Required response: data_o=5dae2223 and v_o=1 throughout, then the remaining words are correct.
REQ-039: Stimulus: en_i=0 for 5 cycles mid-FILL at word 7. Required response: ready_o=0 and no word accepted; the digest after resuming equals REQ-036.
REQ-040: Stimulus: reset_i pulsed low at word 9, then "abc" resent. Required response: the REQ-036 digest, with no residue from the partial block.
REQ-041: Stimulus: two "abc" messages back to back. Required response: two identical REQ-036 digests, confirming H returns to the IV.
